// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, functs, FSM states, ALU codes and decode helpers for the multicycle core
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} aluOp_t;
  function automatic logic isLegal(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_RTYPE ? fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL}
                          : op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
  endfunction
  // Non-R-type instructions only ever need the adder (addi, lw/sw address).
  function automatic aluOp_t aluSel(input logic [5:0] op, input logic [5:0] fn);
    return op != OP_RTYPE ? ALU_ADD :
           fn == F_SUB ? ALU_SUB : fn == F_AND ? ALU_AND : fn == F_OR ? ALU_OR :
           fn == F_SLT ? ALU_SLT : fn == F_SLL ? ALU_SLL : fn == F_SRL ? ALU_SRL : ALU_ADD;
  endfunction
  function automatic logic [31:0] aluCalc(input aluOp_t op, input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] sh);
    case (op)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return {31'b0, $signed(x) < $signed(y)};
      ALU_SLL: return y << sh;
      ALU_SRL: return y >> sh;
      default: return x + y;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: instruction-sequencing FSM, control strobes and memory wait-limit watchdog
module multicycle_control
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       memReady,
  input  logic [1:0] addrLow,
  input  logic       equal,
  output logic       memReq,
  output logic       memWe,
  output logic       addrSel,
  output logic       irWrite,
  output logic       decWrite,
  output logic       aluOutWrite,
  output logic       mdrWrite,
  output logic       regWrite,
  output logic       pcInc,
  output logic       pcBranch,
  output logic       pcJump,
  output logic       halt,
  output aluOp_t     aluOp
);
  state_t state, next;
  logic [31:0] waitCnt;
  logic timeout;
  assign timeout = WAIT_LIMIT != 0 && memReq && !memReady && waitCnt == 32'(WAIT_LIMIT - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_FETCH;
      waitCnt <= '0;
    end else begin
      state   <= next;
      waitCnt <= (memReq && !memReady) ? waitCnt + 32'd1 : '0;
    end
  end
  always_comb begin
    next        = state;
    memReq      = rst && (state == S_FETCH || state == S_MEM);
    memWe       = memReq && state == S_MEM && opcode == OP_SW;
    addrSel     = state == S_MEM;
    irWrite     = memReq && state == S_FETCH && memReady;
    decWrite    = state == S_DECODE;
    aluOutWrite = state == S_EXEC;
    mdrWrite    = memReq && state == S_MEM && memReady && opcode == OP_LW;
    regWrite    = state == S_WB;
    pcInc       = irWrite;
    pcBranch    = state == S_EXEC && (opcode == OP_BEQ ? equal : opcode == OP_BNE && !equal);
    pcJump      = state == S_EXEC && opcode == OP_J;
    halt        = state == S_HALT;
    aluOp       = aluSel(opcode, funct);
    case (state)
      S_FETCH:  next = timeout ? S_HALT : memReady ? S_DECODE : S_FETCH;
      S_DECODE: next = isLegal(opcode, funct) ? S_EXEC : S_HALT;
      S_EXEC:   next = (opcode == OP_LW || opcode == OP_SW) ? (addrLow != 2'b00 ? S_HALT : S_MEM) :
                       (opcode == OP_RTYPE || opcode == OP_ADDI) ? S_WB : S_FETCH;
      S_MEM:    next = timeout ? S_HALT : !memReady ? S_MEM : opcode == OP_LW ? S_WB : S_FETCH;
      S_WB:     next = S_FETCH;
      default:  next = S_HALT;
    endcase
  end
endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle MIPS-subset datapath sharing one ALU and one req/ready memory port
module multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halt,
  output logic [31:0] pc_out
);
  logic [31:0] pc, ir, a, b, imm, aluOut, mdr, aluRes, wrData;
  logic [31:0] regFile [32];
  logic [4:0] wrReg;
  logic addrSel, irWrite, decWrite, aluOutWrite, mdrWrite, regWrite, pcInc, pcBranch, pcJump;
  aluOp_t aluOp;
  multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT)) control (
    .clk(clk), .rst(rst), .opcode(ir[31:26]), .funct(ir[5:0]), .memReady(mem_ready),
    .addrLow(aluRes[1:0]), .equal(a == b), .memReq(mem_req), .memWe(mem_we), .addrSel(addrSel),
    .irWrite(irWrite), .decWrite(decWrite), .aluOutWrite(aluOutWrite), .mdrWrite(mdrWrite),
    .regWrite(regWrite), .pcInc(pcInc), .pcBranch(pcBranch), .pcJump(pcJump), .halt(halt),
    .aluOp(aluOp)
  );
  always_comb begin
    aluRes    = aluCalc(aluOp, a, ir[31:26] == OP_RTYPE ? b : imm, ir[10:6]);
    wrReg     = ir[31:26] == OP_RTYPE ? ir[15:11] : ir[20:16];
    wrData    = ir[31:26] == OP_LW ? mdr : aluOut;
    mem_addr  = addrSel ? aluOut : pc;
    mem_wdata = b;
    pc_out    = pc;
  end
  // Branch offsets apply to the PC already advanced during fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      imm    <= '0;
      aluOut <= '0;
      mdr    <= '0;
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else begin
      if (irWrite) ir <= mem_rdata;
      if (pcInc) pc <= pc + 32'd4;
      else if (pcBranch) pc <= pc + {imm[29:0], 2'b00};
      else if (pcJump) pc <= {pc[31:28], ir[25:0], 2'b00};
      if (decWrite) begin
        a   <= regFile[ir[25:21]];
        b   <= regFile[ir[20:16]];
        imm <= {{16{ir[15]}}, ir[15:0]};
      end
      if (aluOutWrite) aluOut <= aluRes;
      if (mdrWrite) mdr <= mem_rdata;
      if (regWrite && wrReg != 5'd0) regFile[wrReg] <= wrData;
    end
  end
endmodule
